operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Accepts one instruction at a time, reads its two source registers from an
// external register bank and presents the operands with the destination on a
// valid/ready output. A 32-entry pending scoreboard blocks issue of any
// instruction whose source is still waiting for a writeback. Writebacks are
// forwarded straight to the register bank's write port.
//
// Build option:
//   OPF_BYPASS_EN - when defined, an instruction whose pending source is
//                   written back in its issue cycle is accepted immediately
//                   and the writeback data replaces the bank read for it.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   issue_valid/ready       instruction issue handshake
//   issue_rs1/rs2/rd/rd_en  source and destination registers
//   op_valid/ready          operand output handshake
//   op_a, op_b              fetched operands (64 bit)
//   op_rd, op_rd_en         destination forwarded with the operands
//   wb_valid/rd/data        writeback request (never back-pressured)
//   rf_ad_a/b, rf_data_a/b  register-bank read ports
//   rf_ad_c, rf_data_wr,
//   rf_wr_acc               register-bank write port
// ---------------------------------------------------------------------------
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_en,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [63:0] op_a,
    output logic [63:0] op_b,
    output logic [4:0]  op_rd,
    output logic        op_rd_en,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic [4:0]  rf_ad_a,
    output logic [4:0]  rf_ad_b,
    output logic [4:0]  rf_ad_c,
    input  logic [63:0] rf_data_a,
    input  logic [63:0] rf_data_b,
    output logic [63:0] rf_data_wr,
    output logic        rf_wr_acc
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        rd_en_q;
    logic        issue_fire;
    logic        bypass_rs1, bypass_rs2;
    logic        hazard_rs1, hazard_rs2;
    logic [63:0] cap_a, cap_b;

    // -----------------------------------------------------------------------
    // Writeback pass-through; a write to r0 never reaches the bank.
    // -----------------------------------------------------------------------
    assign rf_ad_c    = wb_rd;
    assign rf_data_wr = wb_data;
    assign rf_wr_acc  = wb_valid && (wb_rd != 5'd0);

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
`ifdef OPF_BYPASS_EN
    // A pending source being written back this very cycle is already resolved.
    assign bypass_rs1 = wb_valid && (wb_rd == issue_rs1);
    assign bypass_rs2 = wb_valid && (wb_rd == issue_rs2);
`else
    assign bypass_rs1 = 1'b0;
    assign bypass_rs2 = 1'b0;
`endif

    assign hazard_rs1  = (issue_rs1 != 5'd0) && pending_q[issue_rs1] && !bypass_rs1;
    assign hazard_rs2  = (issue_rs2 != 5'd0) && pending_q[issue_rs2] && !bypass_rs2;
    assign issue_ready = (state_q == IDLE) && !hazard_rs1 && !hazard_rs2;
    assign issue_fire  = issue_valid && issue_ready;

    assign op_valid = (state_q == HOLD);
    assign rf_ad_a  = (state_q == IDLE) ? 5'd0 : rs1_q;
    assign rf_ad_b  = (state_q == IDLE) ? 5'd0 : rs2_q;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_fire) state_d = READ;
            READ:    state_d = HOLD;
            HOLD:    if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // Pending scoreboard: clear on writeback, set on issue; set is applied
    // last so it wins on a same-register collision. r0 is never pending.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_rd] = 1'b0;
        if (issue_fire && issue_rd_en) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // -----------------------------------------------------------------------
    // Instruction latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            rd_en_q <= 1'b0;
        end else if (issue_fire) begin
            rs1_q   <= issue_rs1;
            rs2_q   <= issue_rs2;
            rd_q    <= issue_rd;
            rd_en_q <= issue_rd_en;
        end
    end

`ifdef OPF_BYPASS_EN
    // Writeback data seen at issue for a pending source; used at capture so
    // the operand does not depend on when the bank write becomes visible.
    logic        ovr_a_en_q, ovr_b_en_q;
    logic [63:0] ovr_a_q, ovr_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_a_en_q <= 1'b0;
            ovr_b_en_q <= 1'b0;
            ovr_a_q    <= '0;
            ovr_b_q    <= '0;
        end else if (issue_fire) begin
            ovr_a_en_q <= bypass_rs1 && pending_q[issue_rs1];
            ovr_b_en_q <= bypass_rs2 && pending_q[issue_rs2];
            ovr_a_q    <= wb_data;
            ovr_b_q    <= wb_data;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Capture mux. A writeback during READ lands in the bank too late for the
    // read in progress, so it is forwarded here; it is younger than any
    // issue-time override and therefore takes priority. r0 always reads 0.
    // -----------------------------------------------------------------------
    always_comb begin
        cap_a = rf_data_a;
        cap_b = rf_data_b;
`ifdef OPF_BYPASS_EN
        if (ovr_a_en_q) cap_a = ovr_a_q;
        if (ovr_b_en_q) cap_b = ovr_b_q;
`endif
        if (wb_valid && (wb_rd == rs1_q)) cap_a = wb_data;
        if (wb_valid && (wb_rd == rs2_q)) cap_b = wb_data;
        if (rs1_q == 5'd0) cap_a = '0;
        if (rs2_q == 5'd0) cap_b = '0;
    end

    // Outputs load only at the end of READ, so they stay frozen through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_rd    <= 5'd0;
            op_rd_en <= 1'b0;
        end else if (state_q == READ) begin
            op_a     <= cap_a;
            op_b     <= cap_b;
            op_rd    <= rd_q;
            op_rd_en <= rd_en_q;
        end
    end

endmodule
